// File: rtl/uart_matrix_pkg.sv
// rtl/uart_matrix_pkg.sv - shared constants, loader state type and frame-length helper
package uart_matrix_pkg;

  localparam int DEFAULT_DIM    = 2;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  function automatic int frame_len(input int dim);
    return dim * dim;
  endfunction

endpackage

// File: rtl/uart_matrix_loader.sv
// rtl/uart_matrix_loader.sv - packs UART RX bytes into a DIMxDIM frame with timeout/error/overrun guards
module uart_matrix_loader
  import uart_matrix_pkg::*;
#(
  parameter int DIM         = DEFAULT_DIM,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_valid,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_err,
  output logic                      mat_valid,
  input  logic                      mat_ready,
  output logic [DIM*DIM*DATA_W-1:0] mat_data,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int N  = frame_len(DIM);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = N * DATA_W;

  loader_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            mat_valid_q, mat_valid_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic good_byte, bad_byte, tmo_hit;

  assign good_byte = rx_valid & ~rx_err;
  assign bad_byte  = rx_valid & rx_err;
  // Fires on the idle cycle whose increment would reach TIMEOUT_CYC-1, so the
  // registered pulse lands exactly TIMEOUT_CYC cycles after the last byte.
  assign tmo_hit   = ~rx_valid && ((32'(tmo_q) + 32'd1) >= (TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    frame_d     = frame_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (good_byte) begin
          frame_d[0 +: DATA_W] = rx_data;
          cnt_d   = CW'(1);
          state_d = (N == 1) ? HOLD : FILL;
        end else if (bad_byte) begin
          frame_err_d = 1'b1;
        end
      end

      FILL: begin
        if (good_byte) begin
          frame_d[32'(cnt_q) * DATA_W +: DATA_W] = rx_data;
          cnt_d = cnt_q + CW'(1);
          tmo_d = '0;
          if (cnt_q == CW'(N - 1)) begin
            state_d = HOLD;
          end
        end else if (bad_byte || tmo_hit) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          tmo_d       = '0;
          state_d     = IDLE;
        end else if (32'(tmo_q) < TIMEOUT_CYC) begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      HOLD: begin
        tmo_d = '0;
        if (mat_ready) begin
          if (good_byte) begin
            frame_d[0 +: DATA_W] = rx_data;
            cnt_d   = CW'(1);
            state_d = (N == 1) ? HOLD : FILL;
          end else begin
            frame_err_d = bad_byte;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end else if (rx_valid) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase

    mat_valid_d = (state_d == HOLD);
    busy_d      = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      frame_q     <= '0;
      mat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      frame_q     <= frame_d;
      mat_valid_q <= mat_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mat_valid = mat_valid_q;
  assign mat_data  = frame_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// tb/tb_uart_matrix_loader.sv - directed self-checking bench for uart_matrix_loader
module tb_uart_matrix_loader;

  localparam int DIM         = 2;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 50;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rx_valid;
  logic [DATA_W-1:0]         rx_data;
  logic                      rx_err;
  logic                      mat_valid;
  logic                      mat_ready;
  logic [DIM*DIM*DATA_W-1:0] mat_data;
  logic                      busy;
  logic                      frame_err;
  logic                      overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_n = 0, ov_n = 0, mv_n = 0, hs_n = 0;
  int fe0, ov0, mv0, hs0;

  always #5 clk = ~clk;

  uart_matrix_loader #(
    .DIM(DIM), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .mat_data(mat_data),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (mat_valid) mv_n++;
    if (mat_valid && mat_ready) hs_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_err   = e;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic snap();
    fe0 = fe_n; ov0 = ov_n; mv0 = mv_n; hs0 = hs_n;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0; mat_ready = 1'b0;
    step();
    check("rst_mat_valid", 32'(mat_valid), 32'd0);
    check("rst_mat_data",  mat_data, 32'h0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun), 32'd0);
    step();
    rst = 1'b0;
    step();

    // basic frame, consumer always ready
    snap();
    mat_ready = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send(8'h04, 1'b0);
    check("t1_valid", 32'(mat_valid), 32'd1);
    check("t1_data",  mat_data, 32'h04030201);
    step();
    check("t1_valid_fall", 32'(mat_valid), 32'd0);
    step();
    check("t1_valid_cycles", 32'(mv_n - mv0), 32'd1);
    check("t1_handshakes",   32'(hs_n - hs0), 32'd1);
    check("t1_no_ferr",      32'(fe_n - fe0), 32'd0);
    check("t1_no_ovr",       32'(ov_n - ov0), 32'd0);

    // inter-byte timeout: pulse lands 50 cycles after the third byte
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    repeat (TIMEOUT_CYC - 2) step();
    check("t2_pre_ferr", 32'(frame_err), 32'd0);
    check("t2_pre_busy", 32'(busy), 32'd1);
    step();
    check("t2_ferr", 32'(frame_err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    step();
    check("t2_ferr_1cyc", 32'(frame_err), 32'd0);
    send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
    check("t2_valid", 32'(mat_valid), 32'd1);
    check("t2_data",  mat_data, 32'h08070605);
    step();

    // framing error mid-frame
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    check("t3_ferr",  32'(frame_err), 32'd1);
    check("t3_busy",  32'(busy), 32'd0);
    check("t3_valid", 32'(mat_valid), 32'd0);
    step();
    send(8'h09, 1'b0); send(8'h09, 1'b0); send(8'h09, 1'b0); send(8'h09, 1'b0);
    check("t3_data", mat_data, 32'h09090909);
    step();

    // overrun while held frame not accepted
    mat_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    check("t4_valid", 32'(mat_valid), 32'd1);
    send(8'hAA, 1'b0);
    check("t4_ovr",        32'(overrun), 32'd1);
    check("t4_data_kept",  mat_data, 32'h04030201);
    check("t4_valid_kept", 32'(mat_valid), 32'd1);
    step();
    check("t4_ovr_1cyc", 32'(overrun), 32'd0);
    snap();
    mat_ready = 1'b1;
    step();
    check("t4_valid_fall", 32'(mat_valid), 32'd0);
    step();
    check("t4_handshakes", 32'(hs_n - hs0), 32'd1);

    // handshake coinciding with first byte of next frame
    mat_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    snap();
    mat_ready = 1'b1;
    send(8'h11, 1'b0);
    mat_ready = 1'b0;
    check("t5_valid_fall", 32'(mat_valid), 32'd0);
    check("t5_busy",       32'(busy), 32'd1);
    send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("t5_valid", 32'(mat_valid), 32'd1);
    check("t5_data",  mat_data, 32'h44332211);
    check("t5_no_ovr", 32'(ov_n - ov0), 32'd0);
    mat_ready = 1'b1;
    step();

    // reset mid-frame, with a byte in the reset cycle
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    snap();
    rst = 1'b1;
    send(8'h77, 1'b0);
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
    check("t6_data",    mat_data, 32'h06050403);
    check("t6_no_ferr", 32'(fe_n - fe0), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_matrix_loader.md
# uart_matrix_loader

Assembles a stream of UART-received bytes into one DIM×DIM matrix frame and presents it to the matrix compute engine with a valid/ready handshake. It sits between the UART RX byte receiver and the matrix compute core inside `asic_top`. It also detects inter-byte timeouts, RX framing errors and overruns so that a partial or corrupt frame never reaches the compute core.

## Interface
- `DIM`, default 2: matrix dimension; frame length is DIM*DIM bytes.
- `DATA_W`, default 8: element width; equals UART byte width.
- `TIMEOUT_CYC`, default 200000: maximum idle cycles allowed between bytes of one frame.
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `rx_valid`  in  1: one-cycle pulse; `rx_data` holds a received byte.
- `rx_data`  in  DATA_W: received byte.
- `rx_err`  in  1: one-cycle pulse; framing error on the current byte, qualified by `rx_valid`.
- `mat_valid`  out  1: the complete frame on `mat_data` is valid.
- `mat_ready`  in  1: the compute core accepts the frame.
- `mat_data`  out  DIM*DIM*DATA_W: frame, row-major. Element k = row*DIM+col occupies bits [k*DATA_W +: DATA_W].
- `busy`  out  1: a frame is partially filled.
- `frame_err`  out  1: one-cycle pulse; a partial frame was discarded.
- `overrun`  out  1: one-cycle pulse; a byte was dropped because the held frame was not yet accepted.

## Operation
- Reset values: `mat_valid`=0, `mat_data`=0, `busy`=0, `frame_err`=0, `overrun`=0. Byte counter and timeout counter are cleared; the state machine enters IDLE.
- IDLE:
  - A good byte (`rx_valid & ~rx_err`) is stored as element 0, the count becomes 1, and the state moves to FILL. When DIM*DIM==1 the state moves directly to HOLD.
  - A byte with `rx_err` is dropped, `frame_err` pulses, and the state stays IDLE.
- FILL:
  - Each good byte is written to element [count], count increments, and the timeout counter clears.
  - When the byte just written is element DIM*DIM-1, the state moves to HOLD.
  - A byte with `rx_err` discards the frame: `frame_err` pulses, count returns to 0, state returns to IDLE. The erroneous byte is not stored.
  - The timeout counter increments on every cycle without `rx_valid`. When it reaches TIMEOUT_CYC-1 with no byte arriving, the frame is discarded, `frame_err` pulses and the state returns to IDLE.
- HOLD:
  - `mat_valid`=1 and `mat_data` is stable until the handshake (`mat_valid & mat_ready`).
  - If the handshake occurs with no byte arriving, the state returns to IDLE.
  - If the handshake occurs in the same cycle as a good byte, the byte becomes element 0 of the next frame: count=1, state moves to FILL.
  - A byte arriving without the handshake is dropped and `overrun` pulses.
- `busy` = (state==FILL).
- Elements not yet written in a new frame retain their stale values. These are never visible, because `mat_valid` is 0 during FILL.
- Counters:
  - The count is $clog2(DIM*DIM+1) bits wide.
  - The timeout counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates; it never wraps.

## Timing
- All outputs are registered.
- `mat_valid` rises in the cycle after the last byte's `rx_valid` pulse (latency 1).
- `mat_valid` falls in the cycle after the handshake, unless a new frame was completed in that same cycle (impossible for DIM≥2).
- `frame_err` and `overrun` pulse exactly one cycle, in the cycle after the causing event.
- Timeout fires exactly TIMEOUT_CYC cycles after the last accepted byte's `rx_valid`.
- `rst` mid-frame or during HOLD:
  - The partial or held frame is discarded without a `frame_err` pulse.
  - A byte arriving in the reset cycle is ignored.
- Back-to-back `rx_valid` on consecutive cycles is supported at full rate.

## Structure
- Shared package `uart_matrix_pkg`:
  - `DATA_W` and `DIM` default constants.
  - A `loader_state_t` enum {IDLE, FILL, HOLD}.
  - A function returning the frame length DIM*DIM.
  - The compute core and the TX serializer import the same package.
- No sub-module: one state machine, one byte counter, one timeout counter, one packed frame register.

## Test plan
- Reset with DIM=2, then send bytes 1,2,3,4 with `mat_ready`=1.
  - Expect `mat_valid` for exactly one cycle, `mat_data`=32'h04030201, and no `frame_err` or `overrun`.
- Send 1,2,3, then idle for TIMEOUT_CYC cycles (use TIMEOUT_CYC=50 in the bench).
  - Expect a `frame_err` pulse at cycle 50 after the third byte and `busy` to drop.
  - Then send 5,6,7,8; expect `mat_data`=32'h08070605.
- Send 1,2, then byte 3 with `rx_err`=1.
  - Expect `frame_err` and a return to IDLE.
  - Then send 9,9,9,9; expect 32'h09090909.
- Hold `mat_ready`=0, send 1,2,3,4, then send 0xAA.
  - Expect an `overrun` pulse and `mat_data` still 32'h04030201.
  - Raise `mat_ready`; expect one handshake and `mat_valid` to fall.
- With a frame in HOLD, assert `mat_ready` in the same cycle as byte 0x11, then send 0x22,0x33,0x44.
  - Expect the second frame 32'h44332211 with no `overrun`.
- Send 1,2, then assert `rst` for one cycle, then send 3,4,5,6.
  - Expect no `frame_err` and `mat_data`=32'h06050403.
